// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // {Q[0], q_1} pairs that request an add or a subtract of M
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_multiplier_if.sv
// Operand/result handshake between the arithmetic unit and the Booth multiplier.
interface booth_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       a_in;
    logic [WIDTH-1:0]       b_in;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, signed_mode, a_in, b_in,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, a_in, b_in,
        output busy, done, product
    );
endinterface

// File: rtl/booth_add_sub.sv
// Combinational W-bit adder/subtractor used for the P +/- M step.
module booth_add_sub #(
    parameter int W = 10
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y
);
    assign y = sub ? (a - b) : (a + b);
endmodule

// File: rtl/booth_multiplier.sv
// Self-sequencing radix-2 Booth multiplier: WIDTH+1 iterations over
// operands extended to WIDTH+1 bits, one guard bit on the accumulator.
module booth_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    booth_multiplier_if.slave  bus
);
    localparam int N  = WIDTH + 1;
    localparam int CW = cnt_width(WIDTH);

    state_t             state_q, state_d;
    logic [N-1:0]       m_q, q_q;
    logic [N:0]         p_q;
    logic               q1_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] product_q;

    logic [1:0]         pair;
    logic [N:0]         m_ext, sum, p_sel, p_next;
    logic [N-1:0]       q_next;
    logic               last_iter;

    function automatic logic [N-1:0] extend(input logic [WIDTH-1:0] x, input logic s);
        return {s & x[WIDTH-1], x};
    endfunction

    assign pair      = {q_q[0], q1_q};
    assign m_ext     = {m_q[N-1], m_q};
    assign last_iter = (cnt_q == CW'(WIDTH));

    booth_add_sub #(.W(N + 1)) u_add_sub (
        .a   (p_q),
        .b   (m_ext),
        .sub (pair == BOOTH_SUB),
        .y   (sum)
    );

    // Arithmetic shift of {P, Q, q_1}; q_1 picks up the old Q[0]
    assign p_sel  = (pair == BOOTH_ADD || pair == BOOTH_SUB) ? sum : p_q;
    assign p_next = {p_sel[N], p_sel[N:1]};
    assign q_next = {p_sel[0], q_q[N-1:1]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_q       <= '0;
            q_q       <= '0;
            p_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        m_q   <= extend(bus.a_in, bus.signed_mode);
                        q_q   <= extend(bus.b_in, bus.signed_mode);
                        p_q   <= '0;
                        q1_q  <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    p_q   <= p_next;
                    q_q   <= q_next;
                    q1_q  <= q_q[0];
                    cnt_q <= cnt_q + CW'(1);
                    // Product is the low 2*WIDTH bits of {P, Q} after the final step
                    if (last_iter) product_q <= {p_next[WIDTH-2:0], q_next};
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;

endmodule
